// File: rtl/spi_signal_unpacker.sv
// spi_signal_unpacker: assembles SPI bytes into NUM_CH x CH_W channel words,
// committing each complete frame atomically to sig_out.
module spi_signal_unpacker #(
    parameter int NUM_CH = 6,
    parameter int CH_W   = 8
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   sof,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    input  logic                   hold,
    output logic [NUM_CH*CH_W-1:0] sig_out,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int TOTAL  = NUM_CH * CH_W;
    localparam int NBYTES = TOTAL / 8;
    localparam int CW     = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RECV, PEND} state_t;

    state_t           state_q, state_d, st;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic [TOTAL-1:0] shadow_q, shadow_d, sh_base, sh_next, sig_q, sig_d;
    logic             done_q, done_d, err_q, err_d, busy_q;

    always_comb begin
        // sof is applied first, so a same-cycle byte lands as byte 0 of a fresh frame
        st       = sof ? RECV : state_q;
        sh_base  = sof ? '0 : shadow_q;
        cnt_base = sof ? '0 : cnt_q;
        sh_next  = TOTAL'({sh_base, byte_in});
        state_d  = st;
        cnt_d    = cnt_base;
        shadow_d = sh_base;
        sig_d    = sig_q;
        done_d   = 1'b0;
        err_d    = sof && state_q != IDLE;
        if (byte_valid && st == RECV) begin
            shadow_d = sh_next;
            cnt_d    = cnt_base + CW'(1);
            if (cnt_base == CW'(NBYTES - 1)) begin
                cnt_d   = '0;
                state_d = hold ? PEND : IDLE;
                sig_d   = hold ? sig_q : sh_next;
                done_d  = !hold;
            end
        end else if (byte_valid) begin
            err_d = 1'b1;
        end
        if (st == PEND && !hold) begin
            sig_d   = shadow_q;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            sig_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sig_q    <= sig_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= state_d != IDLE;
        end
    end

    assign sig_out    = sig_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_spi_signal_unpacker.sv
// tb_spi_signal_unpacker: random and directed stimulus checked every cycle
// against a queue-based frame model, plus literal checks that pin the model.
module tb_spi_signal_unpacker;
    logic        clk = 1'b0;
    logic        nreset = 1'b0, sof = 1'b0, bv = 1'b0, hold = 1'b0;
    logic [7:0]  b = 8'h00;
    logic [47:0] sig;
    logic        done, err, busy;
    logic        nreset2 = 1'b0, sof2 = 1'b0, bv2 = 1'b0, hold2 = 1'b0;
    logic [7:0]  b2 = 8'h00;
    logic [63:0] sig2;
    logic        done2, err2, busy2;

    always #5 clk = ~clk;

    spi_signal_unpacker dut (
        .clk(clk), .nreset(nreset), .sof(sof), .byte_valid(bv), .byte_in(b),
        .hold(hold), .sig_out(sig), .frame_done(done), .frame_err(err), .busy(busy)
    );

    spi_signal_unpacker #(.NUM_CH(4), .CH_W(16)) dut2 (
        .clk(clk), .nreset(nreset2), .sof(sof2), .byte_valid(bv2), .byte_in(b2),
        .hold(hold2), .sig_out(sig2), .frame_done(done2), .frame_err(err2), .busy(busy2)
    );

    logic [7:0]  q[$];
    bit          rcv, pend, e_done, e_err, e_busy;
    logic [47:0] e_sig;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [47:0] pack();
        logic [47:0] v = '0;
        foreach (q[i]) v = {v[39:0], q[i]};
        return v;
    endfunction

    task automatic model_step();
        bit p0;
        e_done = 0;
        e_err  = 0;
        if (!nreset) begin
            q.delete();
            rcv = 0; pend = 0; e_sig = '0; e_busy = 0;
            return;
        end
        if (sof) begin
            e_err = rcv || pend;
            q.delete();
            rcv = 1; pend = 0;
        end
        p0 = pend;
        if (bv) begin
            if (rcv) begin
                q.push_back(b);
                if (q.size() == 6) begin
                    rcv = 0;
                    if (hold) pend = 1;
                    else begin e_sig = pack(); e_done = 1; q.delete(); end
                end
            end else e_err = 1;
        end
        if (p0 && !hold) begin
            e_sig = pack(); e_done = 1; pend = 0; q.delete();
        end
        e_busy = rcv || pend;
    endtask

    task automatic cyc(input bit s, input bit v, input logic [7:0] d, input bit h, input bit r);
        sof = s; bv = v; b = d; hold = h; nreset = r;
        model_step();
        @(posedge clk);
        #1;
        chk("sig_out", 64'(sig), 64'(e_sig));
        chk("frame_done", 64'(done), 64'(e_done));
        chk("frame_err", 64'(err), 64'(e_err));
        chk("busy", 64'(busy), 64'(e_busy));
    endtask

    task automatic frame(input logic [47:0] f, input bit h);
        logic [47:0] t = f;
        cyc(1, 0, 8'h00, h, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, t[47:40], h, 1);
            t = t << 8;
        end
    endtask

    task automatic cyc2(input bit s, input bit v, input logic [7:0] d, input bit r);
        sof2 = s; bv2 = v; b2 = d; hold2 = 0; nreset2 = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit h = 0;
        logic [63:0] f2 = 64'hDEADBEEFCAFE1234;
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("reset sig_out", 64'(sig), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        frame(48'h5566778899AA, 0);
        chk("lit frame1", 64'(sig), 64'h5566778899AA);
        chk("lit ch0", 64'(sig[47:40]), 64'h55);
        chk("lit ch5", 64'(sig[7:0]), 64'hAA);
        chk("lit done1", 64'(done), 64'h1);
        cyc(0, 0, 8'h00, 0, 1);
        frame(48'h111213141516, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 1, 1);
            chk("lit hold sig", 64'(sig), 64'h5566778899AA);
            chk("lit hold busy", 64'(busy), 64'h1);
        end
        cyc(0, 0, 8'h00, 0, 1);
        chk("lit hold commit", 64'(sig), 64'h111213141516);
        chk("lit hold done", 64'(done), 64'h1);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(0, 1, 8'h11, 0, 1);
        cyc(0, 1, 8'h22, 0, 1);
        cyc(0, 1, 8'h33, 0, 1);
        frame(48'h010203040506, 0);
        chk("lit short frame", 64'(sig), 64'h010203040506);
        cyc(0, 1, 8'h5A, 0, 1);
        chk("lit idle byte err", 64'(err), 64'h1);
        frame(48'hA1A2A3A4A5A6, 1);
        cyc(0, 1, 8'h77, 1, 1);
        chk("lit overrun err", 64'(err), 64'h1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("lit overrun commit", 64'(sig), 64'hA1A2A3A4A5A6);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(0, 1, 8'hC1, 0, 1);
        cyc(0, 1, 8'hC2, 0, 1);
        cyc(0, 1, 8'hC3, 0, 1);
        cyc(0, 0, 8'h00, 0, 0);
        chk("lit rst sig", 64'(sig), 64'h0);
        chk("lit rst busy", 64'(busy), 64'h0);
        chk("lit rst done", 64'(done), 64'h0);
        frame(48'hB0B1B2B3B4B5, 0);
        chk("lit post rst", 64'(sig), 64'hB0B1B2B3B4B5);
        cyc(1, 1, 8'hE0, 1, 1);
        chk("lit sof+byte busy", 64'(busy), 64'h1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) h = !h;
            cyc($urandom_range(24) == 0, $urandom_range(9) < 6, 8'($urandom),
                h, $urandom_range(299) != 0);
        end
        cyc2(0, 0, 8'h00, 0);
        cyc2(1, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) begin
            cyc2(0, 1, f2[63:56], 1);
            f2 = f2 << 8;
        end
        chk("w16 sig", sig2, 64'hDEADBEEFCAFE1234);
        chk("w16 ch2", 64'(sig2[31:16]), 64'hCAFE);
        chk("w16 done", 64'(done2), 64'h1);
        chk("w16 err", 64'(err2), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
